ahblite_master_arbiter: RTL and testbench

- Two-master AHB-Lite arbiter in front of the system address decoder and slave mux.
- Shares one AHB-Lite slave-side bus between M0 (Cortex-M0 core) and M1 (DMA/debug master).
- Forwards the granted master's address phase and tracks the data-phase owner.
- Routes HRDATA/HRESP/HREADY back to the correct master and stalls the non-granted master without buffering.

---
 rtl/ahblite_master_arbiter.sv | 129 ++++++++++++
 tb/tb_ahblite_master_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ahblite_master_arbiter.sv
// Two-master AHB-Lite arbiter: forwards the address-phase owner's signals to the shared
// slave-side bus, tracks the data-phase owner, and routes HREADY/HRESP/HRDATA back.
// Optional: define AHB_ARB_PARK_EN to park the bus on DEFAULT_MASTER when nobody requests.
module ahblite_master_arbiter #(
  parameter bit DEFAULT_MASTER = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [2:0]  M0_HBURST,
  input  logic [3:0]  M0_HPROT,
  input  logic        M0_HMASTLOCK,
  input  logic [31:0] M0_HWDATA,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [2:0]  M1_HBURST,
  input  logic [3:0]  M1_HPROT,
  input  logic        M1_HMASTLOCK,
  input  logic [31:0] M1_HWDATA,
  output logic        M0_HREADY,
  output logic        M0_HRESP,
  output logic [31:0] M0_HRDATA,
  output logic        M1_HREADY,
  output logic        M1_HRESP,
  output logic [31:0] M1_HRDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  output logic        HMASTER,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA
);

  logic addr_owner_q, addr_owner_d;
  logic data_owner_q, data_owner_d;
  logic data_active_q, data_active_d;
  logic locked_q, locked_d;

  logic owner_idle;
  logic other_req;
  logic switch_req;
  logic m0_data;
  logic m1_data;

  // Address/control mux from the address-phase owner; write data from the data-phase owner.
  always_comb begin
    if (addr_owner_q) begin
      HADDR     = M1_HADDR;
      HTRANS    = M1_HTRANS;
      HWRITE    = M1_HWRITE;
      HSIZE     = M1_HSIZE;
      HBURST    = M1_HBURST;
      HPROT     = M1_HPROT;
      HMASTLOCK = M1_HMASTLOCK;
    end else begin
      HADDR     = M0_HADDR;
      HTRANS    = M0_HTRANS;
      HWRITE    = M0_HWRITE;
      HSIZE     = M0_HSIZE;
      HBURST    = M0_HBURST;
      HPROT     = M0_HPROT;
      HMASTLOCK = M0_HMASTLOCK;
    end
    HWDATA  = data_owner_q ? M1_HWDATA : M0_HWDATA;
    HMASTER = addr_owner_q;
  end

  // Next-state: arbitration and data-phase tracking advance only when the bus is ready.
  always_comb begin
    owner_idle    = (HTRANS == 2'b00);
    other_req     = addr_owner_q ? M0_HTRANS[1] : M1_HTRANS[1];
    switch_req    = owner_idle && !locked_q && !HMASTLOCK && other_req;
    addr_owner_d  = addr_owner_q;
    data_owner_d  = data_owner_q;
    data_active_d = data_active_q;
    locked_d      = locked_q;
    if (HREADY) begin
      data_owner_d  = addr_owner_q;
      data_active_d = HTRANS[1];
      locked_d      = HMASTLOCK;
      if (switch_req) begin
        addr_owner_d = ~addr_owner_q;
`ifdef AHB_ARB_PARK_EN
      end else if (owner_idle && !locked_q && !M0_HTRANS[1] && !M1_HTRANS[1]) begin
        addr_owner_d = DEFAULT_MASTER;
`endif
      end
    end
  end

  // State registers with synchronous reset; in-flight transfers are dropped on reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_owner_q  <= DEFAULT_MASTER;
      data_owner_q  <= DEFAULT_MASTER;
      data_active_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      addr_owner_q  <= addr_owner_d;
      data_owner_q  <= data_owner_d;
      data_active_q <= data_active_d;
      locked_q      <= locked_d;
    end
  end

  // Response routing: a requesting non-owner is stalled, an idle non-owner sees ready.
  always_comb begin
    m0_data   = !data_owner_q && data_active_q;
    m1_data   = data_owner_q && data_active_q;
    M0_HREADY = (!addr_owner_q || m0_data) ? HREADY : ~M0_HTRANS[1];
    M1_HREADY = (addr_owner_q || m1_data) ? HREADY : ~M1_HTRANS[1];
    M0_HRESP  = m0_data ? HRESP : 1'b0;
    M1_HRESP  = m1_data ? HRESP : 1'b0;
    M0_HRDATA = !data_owner_q ? HRDATA : 32'h0;
    M1_HRDATA = data_owner_q ? HRDATA : 32'h0;
  end

endmodule

// File: tb/tb_ahblite_master_arbiter.sv
module tb_ahblite_master_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] M0_HADDR, M1_HADDR;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic [2:0]  M0_HBURST, M1_HBURST;
  logic [3:0]  M0_HPROT, M1_HPROT;
  logic        M0_HMASTLOCK, M1_HMASTLOCK;
  logic [31:0] M0_HWDATA, M1_HWDATA;
  logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
  logic [31:0] M0_HRDATA, M1_HRDATA;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HMASTER, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int tests_run = 0;
  int fails = 0;

  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

  ahblite_master_arbiter #(.DEFAULT_MASTER(1'b0)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HBURST(M0_HBURST), .M0_HPROT(M0_HPROT), .M0_HMASTLOCK(M0_HMASTLOCK),
    .M0_HWDATA(M0_HWDATA),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HBURST(M1_HBURST), .M1_HPROT(M1_HPROT), .M1_HMASTLOCK(M1_HMASTLOCK),
    .M1_HWDATA(M1_HWDATA),
    .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP), .M0_HRDATA(M0_HRDATA),
    .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP), .M1_HRDATA(M1_HRDATA),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HMASTER(HMASTER),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks follow a further 1ns settle.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn = 1'b0;
    M0_HADDR = '0; M0_HTRANS = IDLE; M0_HWRITE = 1'b0; M0_HSIZE = 3'd2; M0_HBURST = '0;
    M0_HPROT = 4'h3; M0_HMASTLOCK = 1'b0; M0_HWDATA = '0;
    M1_HADDR = '0; M1_HTRANS = IDLE; M1_HWRITE = 1'b0; M1_HSIZE = 3'd2; M1_HBURST = '0;
    M1_HPROT = 4'h3; M1_HMASTLOCK = 1'b0; M1_HWDATA = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    tick(); tick();
    HRESETn = 1'b1; #1;
    check("reset_hmaster", {31'b0, HMASTER}, 32'd0);
    check("reset_htrans", {30'b0, HTRANS}, 32'd0);

    // Single M0 read with M1 idle
    M0_HTRANS = NONSEQ; M0_HADDR = 32'h0000_0010; #1;
    check("rd_haddr", HADDR, 32'h10);
    check("rd_htrans", {30'b0, HTRANS}, {30'b0, NONSEQ});
    check("rd_m1_ready_idle", {31'b0, M1_HREADY}, 32'd1);
    tick();
    M0_HTRANS = IDLE; HRDATA = 32'hA5A5_5A5A; #1;
    check("rd_m0_hrdata", M0_HRDATA, 32'hA5A5_5A5A);
    check("rd_m1_hrdata", M1_HRDATA, 32'h0);
    check("rd_m1_hready", {31'b0, M1_HREADY}, 32'd1);

    // M1 requests while M0 streams; switch after M0 IDLE
    M0_HTRANS = NONSEQ; M0_HADDR = 32'h100;
    M1_HTRANS = NONSEQ; M1_HADDR = 32'h2000_0000; M1_HWRITE = 1'b1; #1;
    check("sw_m1_stalled", {31'b0, M1_HREADY}, 32'd0);
    check("sw_haddr_m0", HADDR, 32'h100);
    tick();
    M0_HADDR = 32'h104; #1;
    check("sw_m1_stalled2", {31'b0, M1_HREADY}, 32'd0);
    tick();
    M0_HTRANS = IDLE; #1;
    check("sw_owner_idle_hmaster", {31'b0, HMASTER}, 32'd0);
    check("sw_m1_stalled3", {31'b0, M1_HREADY}, 32'd0);
    tick();
    check("sw_hmaster_m1", {31'b0, HMASTER}, 32'd1);
    check("sw_haddr_m1", HADDR, 32'h2000_0000);
    check("sw_m1_hready", {31'b0, M1_HREADY}, 32'd1);
    tick();

    // M1 write data phase with three wait states; M0 requests meanwhile
    M1_HTRANS = IDLE; M1_HWDATA = 32'h1234_5678; HREADY = 1'b0;
    M0_HTRANS = NONSEQ; M0_HADDR = 32'h300; #1;
    for (int i = 0; i < 3; i++) begin
      check("ws_hwdata", HWDATA, 32'h1234_5678);
      check("ws_hmaster", {31'b0, HMASTER}, 32'd1);
      check("ws_m0_stalled", {31'b0, M0_HREADY}, 32'd0);
      check("ws_m1_hready", {31'b0, M1_HREADY}, 32'd0);
      tick();
    end
    HREADY = 1'b1; #1;
    check("ws_m1_done", {31'b0, M1_HREADY}, 32'd1);
    check("ws_hwdata_last", HWDATA, 32'h1234_5678);
    tick();
    check("ws_switch_m0", {31'b0, HMASTER}, 32'd0);
    check("ws_haddr_m0", HADDR, 32'h300);

    // Locked M0 sequence holds the bus across IDLE
    M0_HMASTLOCK = 1'b1; M1_HWRITE = 1'b0;
    M1_HTRANS = NONSEQ; M1_HADDR = 32'h2000_0040;
    tick();
    M0_HTRANS = IDLE; #1;
    tick();
    check("lk_hold1", {31'b0, HMASTER}, 32'd0);
    check("lk_m1_stalled", {31'b0, M1_HREADY}, 32'd0);
    M0_HMASTLOCK = 1'b0; #1;
    tick();
    check("lk_hold2", {31'b0, HMASTER}, 32'd0);
    tick();
    check("lk_release", {31'b0, HMASTER}, 32'd1);
    check("lk_haddr_m1", HADDR, 32'h2000_0040);

    // ERROR on M1 data phase; M1 cancels with IDLE in the second cycle
    M0_HTRANS = NONSEQ; M0_HADDR = 32'h400;
    tick();
    M1_HTRANS = NONSEQ; M1_HADDR = 32'h2000_0044; HREADY = 1'b0; HRESP = 1'b1; #1;
    check("er1_m1_hresp", {31'b0, M1_HRESP}, 32'd1);
    check("er1_m0_hresp", {31'b0, M0_HRESP}, 32'd0);
    check("er1_m1_hready", {31'b0, M1_HREADY}, 32'd0);
    tick();
    HREADY = 1'b1; M1_HTRANS = IDLE; #1;
    check("er2_m1_hresp", {31'b0, M1_HRESP}, 32'd1);
    check("er2_m1_hready", {31'b0, M1_HREADY}, 32'd1);
    check("er2_m0_hresp", {31'b0, M0_HRESP}, 32'd0);
    tick();
    HRESP = 1'b0; #1;
    check("er_switch_m0", {31'b0, HMASTER}, 32'd0);
    check("er_haddr_m0", HADDR, 32'h400);
    check("er_m0_hready", {31'b0, M0_HREADY}, 32'd1);

    // Reset while M1 owns mid-burst
    M0_HTRANS = IDLE; M1_HTRANS = NONSEQ; M1_HADDR = 32'h2000_0080;
    tick();
    check("rb_m1_owns", {31'b0, HMASTER}, 32'd1);
    M1_HTRANS = SEQ; M1_HADDR = 32'h2000_0084;
    tick();
    HRESETn = 1'b0; HRESP = 1'b1;
    tick();
    check("rb_hmaster", {31'b0, HMASTER}, 32'd0);
    check("rb_htrans", {30'b0, HTRANS}, 32'd0);
    check("rb_m1_hresp", {31'b0, M1_HRESP}, 32'd0);
    check("rb_m0_hresp", {31'b0, M0_HRESP}, 32'd0);
    check("rb_m1_stalled", {31'b0, M1_HREADY}, 32'd0);

    // Idle bus behaviour: parked on default master only when parking is built in
    HRESETn = 1'b1; HRESP = 1'b0; M1_HTRANS = NONSEQ; M1_HADDR = 32'h2000_0100;
    tick();
    check("pk_m1_owns", {31'b0, HMASTER}, 32'd1);
    M1_HTRANS = IDLE;
    tick();
`ifdef AHB_ARB_PARK_EN
    check("pk_idle_hmaster", {31'b0, HMASTER}, 32'd0);
`else
    check("pk_idle_hmaster", {31'b0, HMASTER}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
